// File: rtl/fpu_issue_unit.sv
// fpu_issue_unit: COP1 register file and one-at-a-time sequencer for a combinational FPU
module fpu_issue_unit #(
   parameter int EXEC_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_op_i,
   input  logic [3:0]  req_func_i,
   input  logic [4:0]  req_fs_i,
   input  logic [4:0]  req_ft_i,
   input  logic [4:0]  req_fd_i,
   input  logic [31:0] req_gpr_i,
   output logic        resp_valid_o,
   output logic        resp_err_o,
   output logic [31:0] resp_data_o,
   output logic [31:0] fpu_a_o,
   output logic [31:0] fpu_b_o,
   output logic [3:0]  fpu_cmd_o,
   input  logic [31:0] fpu_result_i
);
   localparam int CW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2;
   localparam logic [1:0] OP_ARITH = 2'd0, OP_MTC1 = 2'd1, OP_MFC1 = 2'd2, OP_RSV = 2'd3;
   logic [1:0]  state_q, state_d, op_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]  fs_q, fd_q;
   logic [31:0] gpr_q, fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d, resp_data_q, resp_data_d, wdata;
   logic [3:0]  fpu_cmd_q, fpu_cmd_d;
   logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic        accept, arith, done, busy, we;
   logic [31:0] regs_q [32];
   always_comb begin
      accept       = req_valid_i && state_q == IDLE;
      arith        = accept && req_op_i == OP_ARITH;
      busy         = state_q == EXEC && cnt_q != '0;
      done         = state_q == EXEC && cnt_q == '0;
      state_d      = accept ? (arith ? EXEC : WB) : busy ? EXEC : IDLE;
      cnt_d        = arith ? CW'(EXEC_CYCLES - 1) : busy ? cnt_q - 1'b1 : cnt_q;
      fpu_a_d      = arith ? regs_q[req_fs_i] : fpu_a_q;
      fpu_b_d      = arith ? regs_q[req_ft_i] : fpu_b_q;
      fpu_cmd_d    = arith ? req_func_i : fpu_cmd_q;
      we           = done || (state_q == WB && op_q == OP_MTC1);
      wdata        = done ? fpu_result_i : gpr_q;
      resp_valid_d = done || state_q == WB;
      resp_err_d   = state_q == WB && op_q == OP_RSV;
      resp_data_d  = done ? fpu_result_i : state_q != WB ? resp_data_q :
                     op_q == OP_MTC1 ? gpr_q : op_q == OP_MFC1 ? regs_q[fs_q] : '0;
   end
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         fs_q         <= '0;
         fd_q         <= '0;
         gpr_q        <= '0;
         fpu_a_q      <= '0;
         fpu_b_q      <= '0;
         fpu_cmd_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fpu_a_q      <= fpu_a_d;
         fpu_b_q      <= fpu_b_d;
         fpu_cmd_q    <= fpu_cmd_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
         if (accept) begin
            op_q  <= req_op_i;
            fs_q  <= req_fs_i;
            fd_q  <= req_fd_i;
            gpr_q <= req_gpr_i;
         end
         if (we) regs_q[fd_q] <= wdata;
      end
   end
   assign req_ready_o  = state_q == IDLE;
   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_data_o  = resp_data_q;
   assign fpu_a_o      = fpu_a_q;
   assign fpu_b_o      = fpu_b_q;
   assign fpu_cmd_o    = fpu_cmd_q;
endmodule

// File: tb/tb_fpu_issue_unit.sv
// tb_fpu_issue_unit: scoreboard bench for fpu_issue_unit with a small behavioural FPU stand-in
module tb_fpu_issue_unit;
   localparam int EC = 2;
   typedef struct {
      logic [31:0] d;
      logic        e;
      int          lat;
   } exp_t;
   logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_ready;
   logic [1:0]  req_op = '0;
   logic [3:0]  req_func = '0;
   logic [4:0]  req_fs = '0, req_ft = '0, req_fd = '0;
   logic [31:0] req_gpr = '0, resp_data, fpu_a, fpu_b, fpu_result;
   logic [3:0]  fpu_cmd;
   logic        resp_valid, resp_err;
   int          checks = 0, failures = 0;
   exp_t        sb[$];
   always #5 clk = ~clk;
   fpu_issue_unit #(.EXEC_CYCLES(EC)) dut (
      .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_func_i(req_func), .req_fs_i(req_fs), .req_ft_i(req_ft),
      .req_fd_i(req_fd), .req_gpr_i(req_gpr), .resp_valid_o(resp_valid), .resp_err_o(resp_err),
      .resp_data_o(resp_data), .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .fpu_cmd_o(fpu_cmd),
      .fpu_result_i(fpu_result)
   );
   // Only the additions the scenarios need are modelled; other commands give a distinct mix
   function automatic logic [31:0] fpu_model(input logic [31:0] a, b, input logic [3:0] c);
      if (c != 4'd0) return a ^ b ^ {28'd0, c};
      if (b == 32'd0) return a;
      if (a == 32'd0) return b;
      if (a == b) return a + 32'h0080_0000;
      if (a == 32'h40C8F5C3 && b == 32'h4048F5C3) return 32'h4116B852;
      return 32'hFFFF_FFFF;
   endfunction
   assign fpu_result = fpu_model(fpu_a, fpu_b, fpu_cmd);
   task automatic send(input logic [1:0] op, input logic [3:0] func, input logic [4:0] fs, ft, fd,
                       input logic [31:0] gpr, output int waits, output int lat,
                       output logic [31:0] d, output logic e);
      req_op = op; req_func = func; req_fs = fs; req_ft = ft; req_fd = fd; req_gpr = gpr;
      req_valid = 1'b1;
      waits = 0;
      while (!req_ready && waits < 20) begin @(posedge clk); #1; waits++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!resp_valid && lat < 20);
      d = resp_data; e = resp_err;
   endtask
   task automatic run(input string name, input logic [1:0] op, input logic [3:0] func,
                      input logic [4:0] fs, ft, fd, input logic [31:0] gpr,
                      input logic [31:0] xd, input logic xe, input int xl);
      int w, l;
      logic [31:0] d;
      logic e;
      exp_t x;
      sb.push_back('{xd, xe, xl});
      send(op, func, fs, ft, fd, gpr, w, l, d, e);
      x = sb.pop_front();
      checks++;
      if (d !== x.d || e !== x.e || l !== x.lat) begin
         failures++;
         $display("FAIL %s: got data=%h err=%b lat=%0d, want data=%h err=%b lat=%0d",
                  name, d, e, l, x.d, x.e, x.lat);
      end
   endtask
   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_err} !== 3'b100 || resp_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_ctrl: got ready/valid/err=%b%b%b data=%h, want 100 data=0",
                  req_ready, resp_valid, resp_err, resp_data);
      end
      checks++;
      if (fpu_a !== 32'd0 || fpu_b !== 32'd0 || fpu_cmd !== 4'd0) begin
         failures++;
         $display("FAIL reset_fpu: got a=%h b=%h cmd=%h, want all 0", fpu_a, fpu_b, fpu_cmd);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      run("mfc1_f5_after_reset", 2'd2, 4'd0, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1);
   endtask
   task automatic test_zero_add;
      run("mtc1_f1", 2'd1, 4'd0, 5'd0, 5'd0, 5'd1, 32'h4048F5C3, 32'h4048F5C3, 1'b0, 1);
      run("add_f2_f1_f0", 2'd0, 4'd0, 5'd1, 5'd0, 5'd2, 32'd0, 32'h4048F5C3, 1'b0, EC);
      run("mfc1_f2", 2'd2, 4'd0, 5'd2, 5'd0, 5'd0, 32'd0, 32'h4048F5C3, 1'b0, 1);
   endtask
   task automatic test_back_to_back;
      int w, l;
      logic [31:0] d;
      logic e;
      exp_t x;
      run("add_f3_f1_f1", 2'd0, 4'd0, 5'd1, 5'd1, 5'd3, 32'd0, 32'h40C8F5C3, 1'b0, EC);
      checks++;
      if (!(resp_valid && req_ready)) begin
         failures++;
         $display("FAIL b2b_ready: got valid=%b ready=%b, want both 1", resp_valid, req_ready);
      end
      sb.push_back('{32'h4116B852, 1'b0, EC});
      send(2'd0, 4'd0, 5'd3, 5'd1, 5'd4, 32'd0, w, l, d, e);
      x = sb.pop_front();
      checks++;
      if (w !== 0 || d !== x.d || e !== x.e || l !== x.lat) begin
         failures++;
         $display("FAIL add_f4_f3_f1: got waits=%0d data=%h err=%b lat=%0d, want waits=0 data=%h err=%b lat=%0d",
                  w, d, e, l, x.d, x.e, x.lat);
      end
   endtask
   task automatic test_reserved;
      run("reserved_op", 2'd3, 4'd0, 5'd1, 5'd1, 5'd2, 32'hDEADBEEF, 32'd0, 1'b1, 1);
      run("mfc1_f2_unchanged", 2'd2, 4'd0, 5'd2, 5'd0, 5'd0, 32'd0, 32'h4048F5C3, 1'b0, 1);
   endtask
   task automatic test_reset_mid_exec;
      int seen = 0;
      req_op = 2'd0; req_func = 4'd0; req_fs = 5'd1; req_ft = 5'd1; req_fd = 5'd6;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      if (resp_valid) seen++;
      reset = 1'b1;
      repeat (4) begin @(posedge clk); #1; if (resp_valid) seen++; end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL abort_no_resp: got %0d resp_valid cycles, want 0", seen);
      end
      run("mfc1_f6_aborted", 2'd2, 4'd0, 5'd6, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1);
      run("mfc1_f1_cleared", 2'd2, 4'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1);
   endtask
   task automatic test_backpressure;
      int busy = 0, n = 0, unstable = 0, extra = 0;
      exp_t x;
      run("mtc1_f7", 2'd1, 4'd0, 5'd0, 5'd0, 5'd7, 32'h12345678, 32'h12345678, 1'b0, 1);
      run("mtc1_f8", 2'd1, 4'd0, 5'd0, 5'd0, 5'd8, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 1);
      sb.push_back('{32'h1D3B5976, 1'b0, EC});
      sb.push_back('{32'h1D3B5976, 1'b0, 1});
      req_op = 2'd0; req_func = 4'd1; req_fs = 5'd7; req_ft = 5'd8; req_fd = 5'd9;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_op = 2'd2; req_fs = 5'd9; req_fd = 5'd0;
      while (!resp_valid && n < 20) begin
         if (!req_ready) busy++;
         if (fpu_a !== 32'h12345678) unstable++;
         @(posedge clk); #1;
         n++;
      end
      x = sb.pop_front();
      checks++;
      if (busy !== EC || n !== x.lat || resp_data !== x.d || resp_err !== x.e) begin
         failures++;
         $display("FAIL bp_arith: got busy=%0d lat=%0d data=%h err=%b, want busy=%0d lat=%0d data=%h err=%b",
                  busy, n, resp_data, resp_err, EC, x.lat, x.d, x.e);
      end
      checks++;
      if (unstable !== 0) begin
         failures++;
         $display("FAIL bp_fpu_a_stable: got %0d unstable cycles, want 0", unstable);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!resp_valid && n < 20);
      x = sb.pop_front();
      checks++;
      if (n !== x.lat || resp_data !== x.d || resp_err !== x.e) begin
         failures++;
         $display("FAIL bp_mfc1: got lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                  n, resp_data, resp_err, x.lat, x.d, x.e);
      end
      repeat (5) begin @(posedge clk); #1; if (resp_valid) extra++; end
      checks++;
      if (extra !== 0 || fpu_a !== 32'h12345678) begin
         failures++;
         $display("FAIL bp_once: got extra=%0d fpu_a=%h, want extra=0 fpu_a=12345678", extra, fpu_a);
      end
   endtask
   initial begin
      test_reset;
      test_zero_add;
      test_back_to_back;
      test_reserved;
      test_reset_mid_exec;
      test_backpressure;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
